// File: rtl/mult_disp_pkg.sv
// rtl/mult_disp_pkg.sv - shared types and segment patterns for the BCD display scanner
package mult_disp_pkg;

   typedef enum logic [0:0] {IDLE, SCAN} scan_state_t;

   // Active-high {g,f,e,d,c,b,a} patterns
   localparam logic [6:0] SEG_0   = 7'h3F;
   localparam logic [6:0] SEG_1   = 7'h06;
   localparam logic [6:0] SEG_2   = 7'h5B;
   localparam logic [6:0] SEG_3   = 7'h4F;
   localparam logic [6:0] SEG_4   = 7'h66;
   localparam logic [6:0] SEG_5   = 7'h6D;
   localparam logic [6:0] SEG_6   = 7'h7D;
   localparam logic [6:0] SEG_7   = 7'h07;
   localparam logic [6:0] SEG_8   = 7'h7F;
   localparam logic [6:0] SEG_9   = 7'h6F;
   localparam logic [6:0] SEG_E   = 7'h79;
   localparam logic [6:0] SEG_OFF = 7'h00;

   function automatic int digits_f(input int n);
      return ((2 * n) / 3) + 1;
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD nibble to active-high 7-segment decoder
module bcd_to_seg7
   import mult_disp_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o,
   output logic       bad_o
);

   always_comb begin
      seg_o = SEG_E;
      case (nibble_i)
         4'd0: seg_o = SEG_0;
         4'd1: seg_o = SEG_1;
         4'd2: seg_o = SEG_2;
         4'd3: seg_o = SEG_3;
         4'd4: seg_o = SEG_4;
         4'd5: seg_o = SEG_5;
         4'd6: seg_o = SEG_6;
         4'd7: seg_o = SEG_7;
         4'd8: seg_o = SEG_8;
         4'd9: seg_o = SEG_9;
         default: seg_o = SEG_E;
      endcase
   end

   assign bad_o = (nibble_i > 4'd9);

endmodule

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - captures a packed BCD product and scans it onto a muxed 7-segment display
module bcd_display_scanner
   import mult_disp_pkg::*;
#(
   parameter int N       = 8,
   parameter int DIGITS  = digits_f(N),
   parameter int CLK_DIV = 50000,
   parameter int SEG_AL  = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DIGITS*4-1:0] bcd_in,
   input  logic                finish,
   output logic [6:0]          seg,
   output logic [DIGITS-1:0]   an,
   output logic                shown,
   output logic                bad_digit
);

   localparam int   PW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int   IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic POL = (SEG_AL != 0);

   scan_state_t         state_q, state_d;
   logic                finish_q;
   logic                rise;
   logic [DIGITS*4-1:0] cap_q, cap_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                shown_q, shown_d;
   logic [6:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   an_q, an_d;

   logic [6:0]          seg_arr [DIGITS];
   logic [DIGITS-1:0]   bad_arr;
   logic [DIGITS-1:0]   blank;
   logic                above;
   logic [6:0]          seg_hi;
   logic [DIGITS-1:0]   an_hi;

   assign rise = finish & ~finish_q;

   for (genvar k = 0; k < DIGITS; k++) begin : g_dec
      bcd_to_seg7 u_dec (
         .nibble_i (cap_q[4*k +: 4]),
         .seg_o    (seg_arr[k]),
         .bad_o    (bad_arr[k])
      );
   end

   // A digit is blank when it and every more-significant digit is zero; "E" counts as non-zero
   always_comb begin
      blank = '0;
      above = 1'b0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         above    = above | (cap_q[4*k +: 4] != 4'd0);
         blank[k] = (k != 0) && !above;
      end
   end

   always_comb begin
      state_d = state_q;
      cap_d   = cap_q;
      presc_d = presc_q;
      idx_d   = idx_q;
      shown_d = shown_q;
      if (rise) begin
         cap_d   = bcd_in;
         shown_d = 1'b1;
         state_d = SCAN;
         presc_d = '0;
         idx_d   = '0;
      end else if (state_q == SCAN) begin
         if (presc_q == PW'(CLK_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
   end

   // Registered outputs follow the current scan slot so an and seg switch on the same edge
   always_comb begin
      seg_hi = SEG_OFF;
      an_hi  = '0;
      if (state_q == SCAN) begin
         an_hi[idx_q] = 1'b1;
         seg_hi       = blank[idx_q] ? SEG_OFF : seg_arr[idx_q];
      end
      seg_d = seg_hi ^ {7{POL}};
      an_d  = an_hi ^ {DIGITS{POL}};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         finish_q <= 1'b0;
         cap_q    <= '0;
         presc_q  <= '0;
         idx_q    <= '0;
         shown_q  <= 1'b0;
         seg_q    <= {7{POL}};
         an_q     <= {DIGITS{POL}};
      end else begin
         state_q  <= state_d;
         finish_q <= finish;
         cap_q    <= cap_d;
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         shown_q  <= shown_d;
         seg_q    <= seg_d;
         an_q     <= an_d;
      end
   end

   assign seg       = seg_q;
   assign an        = an_q;
   assign shown     = shown_q;
   assign bad_digit = |bad_arr;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - directed self-checking bench for bcd_display_scanner
module tb_bcd_display_scanner;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        finish = 1'b0;
   logic [23:0] bcd_in = '0;
   logic [6:0]  seg;
   logic [5:0]  an;
   logic        shown;
   logic        bad_digit;

   int n_total = 0;
   int n_bad   = 0;
   int s       = 0;

   bcd_display_scanner #(
      .N       (8),
      .DIGITS  (6),
      .CLK_DIV (4),
      .SEG_AL  (1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bcd_in    (bcd_in),
      .finish    (finish),
      .seg       (seg),
      .an        (an),
      .shown     (shown),
      .bad_digit (bad_digit)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench just after the edge that samples the rising finish
   task automatic raise_finish(input logic [23:0] v);
      finish = 1'b0;
      step();
      bcd_in = v;
      finish = 1'b1;
      step();
   endtask

   task automatic test_reset();
      reset  = 1'b0;
      finish = 1'b0;
      bcd_in = '0;
      repeat (3) step();
      if (seg !== 7'h7F || an !== 6'h3F || shown !== 1'b0 || bad_digit !== 1'b0) begin
         $display("FAIL reset_state seg=%h an=%h shown=%b bad=%b want seg=7f an=3f shown=0 bad=0",
                  seg, an, shown, bad_digit);
         n_bad++;
      end
      n_total++;
      @(negedge clk);
      reset = 1'b1;
      repeat (5) step();
      if (seg !== 7'h7F || an !== 6'h3F || shown !== 1'b0) begin
         $display("FAIL idle_blank seg=%h an=%h shown=%b want seg=7f an=3f shown=0", seg, an, shown);
         n_bad++;
      end
      n_total++;
   endtask

   task automatic test_scan_full();
      logic [6:0] exp_seg [6] = '{7'h12, 7'h24, 7'h40, 7'h12, 7'h02, 7'h7F};
      logic [5:0] ea;
      raise_finish(24'h065025);
      if (shown !== 1'b1 || bad_digit !== 1'b0) begin
         $display("FAIL capture_flags shown=%b bad=%b want shown=1 bad=0", shown, bad_digit);
         n_bad++;
      end
      n_total++;
      for (int d = 0; d < 7; d++) begin
         for (int c = 0; c < 4; c++) begin
            step();
            ea = '1;
            ea[d % 6] = 1'b0;
            if (an !== ea || seg !== exp_seg[d % 6]) begin
               $display("FAIL scan_255sq digit=%0d cyc=%0d an=%h seg=%h want an=%h seg=%h",
                        d, c, an, seg, ea, exp_seg[d % 6]);
               n_bad++;
            end
            n_total++;
         end
      end
   endtask

   task automatic test_zero_hold();
      logic [6:0] exp_seg [6] = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      logic [6:0] exp_new [6] = '{7'h19, 7'h19, 7'h79, 7'h7F, 7'h7F, 7'h7F};
      logic [5:0] ea;
      int         d;
      raise_finish(24'h000000);
      s = 0;
      for (int i = 0; i < 24; i++) begin
         step();
         s++;
         d = ((s - 1) / 4) % 6;
         ea = '1;
         ea[d] = 1'b0;
         if (an !== ea || seg !== exp_seg[d]) begin
            $display("FAIL scan_zero s=%0d an=%h seg=%h want an=%h seg=%h", s, an, seg, ea, exp_seg[d]);
            n_bad++;
         end
         n_total++;
      end
      bcd_in = 24'h123456;
      repeat (100) begin
         step();
         s++;
      end
      for (int i = 0; i < 24; i++) begin
         step();
         s++;
         d = ((s - 1) / 4) % 6;
         ea = '1;
         ea[d] = 1'b0;
         if (an !== ea || seg !== exp_seg[d]) begin
            $display("FAIL hold_no_recapture s=%0d an=%h seg=%h want an=%h seg=%h",
                     s, an, seg, ea, exp_seg[d]);
            n_bad++;
         end
         n_total++;
      end
      // Drop finish, then raise it again in the middle of digit 3's slot
      finish = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (((s - 1) / 4) % 6 == 3 && (s - 1) % 4 == 1) break;
         step();
         s++;
      end
      if (((s - 1) / 4) % 6 != 3) begin
         $display("FAIL midscan_reach slot=%0d want 3", ((s - 1) / 4) % 6);
         n_bad++;
      end
      n_total++;
      bcd_in = 24'h000144;
      finish = 1'b1;
      step();
      for (int i = 0; i < 24; i++) begin
         step();
         d = i / 4;
         ea = '1;
         ea[d] = 1'b0;
         if (an !== ea || seg !== exp_new[d]) begin
            $display("FAIL recapture_144 i=%0d an=%h seg=%h want an=%h seg=%h", i, an, seg, ea, exp_new[d]);
            n_bad++;
         end
         n_total++;
      end
   endtask

   task automatic test_bad_digit();
      logic [6:0] exp_seg [6] = '{7'h24, 7'h79, 7'h40, 7'h06, 7'h7F, 7'h7F};
      logic [5:0] ea;
      raise_finish(24'h00A012);
      if (bad_digit !== 1'b1) begin
         $display("FAIL bad_set bad=%b want 1", bad_digit);
         n_bad++;
      end
      n_total++;
      for (int i = 0; i < 24; i++) begin
         step();
         ea = '1;
         ea[i / 4] = 1'b0;
         if (an !== ea || seg !== exp_seg[i / 4]) begin
            $display("FAIL scan_bad i=%0d an=%h seg=%h want an=%h seg=%h", i, an, seg, ea, exp_seg[i / 4]);
            n_bad++;
         end
         n_total++;
      end
      raise_finish(24'h000001);
      if (bad_digit !== 1'b0) begin
         $display("FAIL bad_clear bad=%b want 0", bad_digit);
         n_bad++;
      end
      n_total++;
      for (int i = 0; i < 5; i++) begin
         step();
         ea = '1;
         ea[i / 4] = 1'b0;
         if (an !== ea || seg !== ((i < 4) ? 7'h79 : 7'h7F)) begin
            $display("FAIL scan_one i=%0d an=%h seg=%h want an=%h seg=%h",
                     i, an, seg, ea, (i < 4) ? 7'h79 : 7'h7F);
            n_bad++;
         end
         n_total++;
      end
   endtask

   task automatic test_async_reset();
      step();
      step();
      #2;
      reset = 1'b0;
      #1;
      if (seg !== 7'h7F || an !== 6'h3F || shown !== 1'b0 || bad_digit !== 1'b0) begin
         $display("FAIL async_reset seg=%h an=%h shown=%b bad=%b want seg=7f an=3f shown=0 bad=0",
                  seg, an, shown, bad_digit);
         n_bad++;
      end
      n_total++;
      finish = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) step();
      if (seg !== 7'h7F || an !== 6'h3F || shown !== 1'b0) begin
         $display("FAIL post_reset_idle seg=%h an=%h shown=%b want seg=7f an=3f shown=0", seg, an, shown);
         n_bad++;
      end
      n_total++;
   endtask

   initial begin
      test_reset();
      test_scan_full();
      test_zero_hold();
      test_bad_digit();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
